// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// opcode/funct constants, ALU op codes and datapath select encodings.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_EX_R       = 4'd2,
        S_EX_I       = 4'd3,
        S_EX_MEMADDR = 4'd4,
        S_MEM_LW     = 4'd5,
        S_MEM_SW     = 4'd6,
        S_WB_ALU     = 4'd7,
        S_WB_LW      = 4'd8,
        S_EX_BEQ     = 4'd9,
        S_EX_JALR    = 4'd10,
        S_HALT       = 4'd11
    } state_e;

    localparam logic [5:0] OP_OTHER0 = 6'h00;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] OP_BEQ    = 6'h04;

    localparam logic [5:0] OP0_ADD  = 6'h20;
    localparam logic [5:0] OP0_SUB  = 6'h22;
    localparam logic [5:0] OP0_AND  = 6'h24;
    localparam logic [5:0] OP0_OR   = 6'h25;
    localparam logic [5:0] OP0_NOR  = 6'h27;
    localparam logic [5:0] OP0_XOR  = 6'h26;
    localparam logic [5:0] OP0_JALR = 6'h09;

    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] MTR_ALUOUT = 2'd0;
    localparam logic [1:0] MTR_MDR    = 2'd1;
    localparam logic [1:0] MTR_PC     = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_A      = 2'd2;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_JALR,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_jump;
    } ctrl_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct classifier; also yields the R-type ALU op.
module instr_class_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e instr_class,
    output logic [2:0]   r_alu_op,
    output logic         illegal
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        r_alu_op    = ALU_ADD;
        case (opcode)
            OP_OTHER0: begin
                case (funct)
                    OP0_ADD:  begin instr_class = CLS_RTYPE; r_alu_op = ALU_ADD; end
                    OP0_SUB:  begin instr_class = CLS_RTYPE; r_alu_op = ALU_SUB; end
                    OP0_AND:  begin instr_class = CLS_RTYPE; r_alu_op = ALU_AND; end
                    OP0_OR:   begin instr_class = CLS_RTYPE; r_alu_op = ALU_OR;  end
                    OP0_NOR:  begin instr_class = CLS_RTYPE; r_alu_op = ALU_NOR; end
                    OP0_XOR:  begin instr_class = CLS_RTYPE; r_alu_op = ALU_XOR; end
                    OP0_JALR: instr_class = CLS_JALR;
                    default:  instr_class = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: instr_class = CLS_ADDI;
            OP_LW:   instr_class = CLS_LW;
            OP_SW:   instr_class = CLS_SW;
            OP_BEQ:  instr_class = CLS_BEQ;
            default: instr_class = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready stalls, sticky illegal
// instruction halt and a retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        halted,
    output logic [31:0] retired
);

    state_e       state_q, state_n;
    ctrl_t        ctrl_q, ctrl_n;
    logic         halted_q;
    logic [31:0]  retired_q;
    instr_class_e instr_class;
    logic [2:0]   r_alu_op;
    logic         illegal;
    logic         fetch_done;

    instr_class_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .instr_class (instr_class),
        .r_alu_op    (r_alu_op),
        .illegal     (illegal)
    );

    // Moore-style controls for state s; outputs are registered off the next state.
    function automatic ctrl_t ctrl_for(input state_e s, input logic wb_rd, input logic [2:0] r_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALU_ADD;
            end
            S_EX_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = r_op;
            end
            S_EX_I, S_EX_MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = MTR_ALUOUT;
                c.reg_dst    = wb_rd ? REG_DST_RD : REG_DST_RT;
            end
            S_MEM_LW: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_SW: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_WB_LW: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RT;
                c.mem_to_reg = MTR_MDR;
            end
            S_EX_BEQ: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_SUB;
                c.pc_source = PCSRC_ALUOUT;
            end
            S_EX_JALR: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RA;
                c.mem_to_reg = MTR_PC;
                c.pc_jump    = 1'b1;
                c.pc_source  = PCSRC_A;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                if (illegal) begin
                    state_n = S_HALT;
                end else begin
                    case (instr_class)
                        CLS_RTYPE:      state_n = S_EX_R;
                        CLS_ADDI:       state_n = S_EX_I;
                        CLS_LW, CLS_SW: state_n = S_EX_MEMADDR;
                        CLS_BEQ:        state_n = S_EX_BEQ;
                        CLS_JALR:       state_n = S_EX_JALR;
                        default:        state_n = S_HALT;
                    endcase
                end
            end
            S_EX_R, S_EX_I: state_n = S_WB_ALU;
            S_EX_MEMADDR:   state_n = (instr_class == CLS_SW) ? S_MEM_SW : S_MEM_LW;
            S_MEM_LW:       if (mem_ready) state_n = S_WB_LW;
            S_MEM_SW:       if (mem_ready) state_n = S_FETCH;
            S_WB_ALU, S_WB_LW, S_EX_BEQ, S_EX_JALR: state_n = S_FETCH;
            S_HALT:         state_n = S_HALT;
            default:        state_n = S_FETCH;
        endcase
        ctrl_n = ctrl_for(state_n, state_q == S_EX_R, r_alu_op);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= ctrl_for(S_FETCH, 1'b0, ALU_ADD);
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q  <= state_n;
            ctrl_q   <= ctrl_n;
            halted_q <= halted_q | (state_n == S_HALT);
            if (state_q != S_FETCH && state_n == S_FETCH)
                retired_q <= retired_q + 32'd1;
        end
    end

    // Fetch completion and the beq decision are Mealy; reset gates the fetch strobes.
    assign fetch_done = (state_q == S_FETCH) && mem_ready && reset;
    assign ir_write   = fetch_done;
    assign pc_write   = fetch_done | ((state_q == S_EX_BEQ) && zero) | ctrl_q.pc_jump;

    assign iord       = ctrl_q.iord;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_source  = ctrl_q.pc_source;
    assign halted     = halted_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-state output vectors, stalls,
// halt behaviour and retirement counting across resets.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic        alu_src_a, halted;
    logic [2:0]  alu_op;
    logic [31:0] retired;

    // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
    //  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, halted}
    logic [18:0] obs;
    assign obs = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, halted};

    int checks = 0;
    int failures = 0;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] exp_v;
        reset = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, exp_v);
        end
        checks++;
        if (retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_retired got=%0d exp=0", retired);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({ir_write, pc_write} !== 2'b11) begin
            failures++;
            $display("FAIL fetch_mealy got=%b exp=11", {ir_write, pc_write});
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [6];
        logic [2:0]  op_exp [6];
        logic [18:0] exp_v;
        fn     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26};
        op_exp = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 6; i++) begin
            opcode = 6'h00;
            funct  = fn[i];
            tick();
            exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, 3'd2, 2'd0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL decode_outputs funct=%h got=%b exp=%b", fn[i], obs, exp_v);
            end
            tick();
            exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, op_exp[i], 2'd0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL ex_r_outputs funct=%h got=%b exp=%b", fn[i], obs, exp_v);
            end
            tick();
            exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL wb_alu_rtype funct=%h got=%b exp=%b", fn[i], obs, exp_v);
            end
            tick();
            checks++;
            if (retired !== 32'(i + 1) || mem_read !== 1'b1) begin
                failures++;
                $display("FAIL rtype_retire got=%0d/%b exp=%0d/1", retired, mem_read, i + 1);
            end
        end
    endtask

    task automatic test_addi();
        logic [18:0] exp_v;
        opcode = 6'h08;
        tick();
        tick();
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 3'd2, 2'd0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL ex_i_outputs got=%b exp=%b", obs, exp_v);
        end
        tick();
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL wb_alu_addi got=%b exp=%b", obs, exp_v);
        end
        tick();
        checks++;
        if (retired !== 32'd7) begin
            failures++;
            $display("FAIL addi_retire got=%0d exp=7", retired);
        end
    endtask

    task automatic test_lw_stall();
        logic [18:0] exp_v;
        opcode = 6'h23;
        mem_ready = 1'b1;
        tick();                           // cycle 2: DECODE
        tick();                           // cycle 3: EX_MEMADDR
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 3'd2, 2'd0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL ex_memaddr_outputs got=%b exp=%b", obs, exp_v);
        end
        mem_ready = 1'b0;
        exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0};
        for (int c = 4; c <= 7; c++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL mem_lw_stall cycle=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL mem_lw_ready got=%b exp=%b", obs, exp_v);
        end
        tick();                           // cycle 8: WB_LW
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0};
        checks++;
        if (obs !== exp_v || retired !== 32'd7) begin
            failures++;
            $display("FAIL wb_lw_cycle8 got=%b/%0d exp=%b/7", obs, retired, exp_v);
        end
        tick();
        checks++;
        if (retired !== 32'd8) begin
            failures++;
            $display("FAIL lw_retire got=%0d exp=8", retired);
        end
    endtask

    task automatic test_fetch_stall_beq();
        logic [18:0] exp_v;
        opcode = 6'h04;
        zero = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({ir_write, pc_write, mem_read} !== 3'b001) begin
            failures++;
            $display("FAIL fetch_stall got=%b exp=001", {ir_write, pc_write, mem_read});
        end
        tick();
        checks++;
        if ({ir_write, pc_write, mem_read} !== 3'b001) begin
            failures++;
            $display("FAIL fetch_stall_hold got=%b exp=001", {ir_write, pc_write, mem_read});
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({ir_write, pc_write, mem_read} !== 3'b111) begin
            failures++;
            $display("FAIL fetch_release got=%b exp=111", {ir_write, pc_write, mem_read});
        end
        tick();
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 3'd3, 2'd1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL beq_taken got=%b exp=%b", obs, exp_v);
        end
        zero = 1'b0;
        #1;
        checks++;
        if (pc_write !== 1'b0) begin
            failures++;
            $display("FAIL beq_zero_drop got=%b exp=0", pc_write);
        end
        tick();
        checks++;
        if (retired !== 32'd9 || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL beq_retire got=%0d/%b exp=9/1", retired, mem_read);
        end
        tick();
        tick();
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 3'd3, 2'd1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL beq_not_taken got=%b exp=%b", obs, exp_v);
        end
        tick();
        checks++;
        if (retired !== 32'd10) begin
            failures++;
            $display("FAIL beq2_retire got=%0d exp=10", retired);
        end
    endtask

    task automatic test_jalr();
        logic [18:0] exp_v;
        opcode = 6'h00;
        funct = 6'h09;
        tick();
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL jalr_outputs got=%b exp=%b", obs, exp_v);
        end
        tick();
        checks++;
        if (retired !== 32'd11 || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL jalr_retire got=%0d/%b exp=11/1", retired, mem_read);
        end
    endtask

    task automatic test_halt();
        opcode = 6'h3F;
        tick();
        tick();
        checks++;
        if (obs !== 19'd1 || retired !== 32'd11) begin
            failures++;
            $display("FAIL halt_enter got=%b/%0d exp=%b/11", obs, retired, 19'd1);
        end
        for (int i = 0; i < 10; i++) begin
            mem_ready = (i % 2 == 0);
            zero = (i % 2 != 0);
            opcode = (i % 3 == 0) ? 6'h23 : 6'h00;
            tick();
            checks++;
            if (obs !== 19'd1) begin
                failures++;
                $display("FAIL halt_quiet cycle=%0d got=%b exp=%b", i, obs, 19'd1);
            end
        end
        checks++;
        if (retired !== 32'd11) begin
            failures++;
            $display("FAIL halt_retired got=%0d exp=11", retired);
        end
        zero = 1'b0;
    endtask

    task automatic test_sw_reset();
        logic [18:0] exp_v;
        logic [18:0] exp_rst;
        exp_rst = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, 1'b0};
        mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== exp_rst || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_from_halt got=%b/%0d exp=%b/0", obs, retired, exp_rst);
        end
        @(negedge clk);
        reset = 1'b1;
        opcode = 6'h2b;
        tick();
        tick();
        tick();
        exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL mem_sw_outputs got=%b exp=%b", obs, exp_v);
        end
        tick();
        checks++;
        if (retired !== 32'd1) begin
            failures++;
            $display("FAIL sw_retire got=%0d exp=1", retired);
        end
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_write !== 1'b1) begin
            failures++;
            $display("FAIL sw_stall got=%b exp=1", mem_write);
        end
        mem_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== exp_rst || retired !== 32'd0) begin
            failures++;
            $display("FAIL sw_abort got=%b/%0d exp=%b/0", obs, retired, exp_rst);
        end
        tick();
        checks++;
        if (obs !== exp_rst || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold got=%b/%0d exp=%b/0", obs, retired, exp_rst);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_bad_funct();
        opcode = 6'h00;
        funct = 6'h03;
        tick();
        tick();
        checks++;
        if (obs !== 19'd1 || retired !== 32'd0) begin
            failures++;
            $display("FAIL bad_funct_halt got=%b/%0d exp=%b/0", obs, retired, 19'd1);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_lw_stall();
        test_fetch_stall_beq();
        test_jalr();
        test_halt();
        test_sw_reset();
        test_bad_funct();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
